// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: state numbering, instruction
// field constants and the datapath select codes it drives.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_FETCH_WB = 4'd2,
    S_DECODE   = 4'd3,
    S_EXEC_R   = 4'd4,
    S_WB_R     = 4'd5,
    S_EXEC_I   = 4'd6,
    S_WB_I     = 4'd7,
    S_ADDR     = 4'd8,
    S_MEM_RD   = 4'd9,
    S_WB_L     = 4'd10,
    S_MEM_WR   = 4'd11,
    S_BRANCH   = 4'd12,
    S_JUMP     = 4'd13,
    S_EXCEPT   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU_NONE marks a funct outside the supported R-type subset.
  function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_NONE;
    endcase
  endfunction

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the sequencer (master) and the datapath (slave): decoded
// instruction fields and ALU flags in, every select and write-enable out.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       ab_write;
  logic       alu_out_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       exception;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, zero, overflow,
    output pc_write, pc_write_cond, i_or_d, mem_write, ir_write, ab_write,
           alu_out_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, pc_source, exception, state_dbg
  );

  modport slave (
    output opcode, funct, zero, overflow,
    input  pc_write, pc_write_cond, i_or_d, mem_write, ir_write, ab_write,
           alu_out_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, alu_op, pc_source, exception, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm_mem_wait_counter.sv
// Counts cycles spent in a memory-access state; done marks the last of MEM_WAIT cycles.
module mem_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);
  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) wait_cnt <= '0;
    else                wait_cnt <= wait_cnt + 3'd1;
  end

  assign done = (wait_cnt == LAST);
endmodule

// File: rtl/mc_control_fsm.sv
// Moore sequencer for a multicycle MIPS-subset datapath (add/sub/and, addi, lw,
// sw, beq, j). Memory states dwell MEM_WAIT cycles; undefined ops and overflow trap.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input logic              clk,
  input logic              reset,
  mc_control_fsm_if.master bus
);
  state_t     state, next_state;
  logic       wait_done, wait_clear;
  logic [2:0] r_op;
  logic       unused_zero;

  // beq is qualified by zero in the datapath via pc_write_cond, not here.
  assign unused_zero = bus.zero;
  assign r_op        = funct_alu_op(bus.funct);

  // Clearing on the final cycle makes the count start at 0 on every entry.
  assign wait_clear = !is_wait_state(state) || wait_done;

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clear (wait_clear),
    .done  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else       state <= next_state;
  end

  assign bus.state_dbg = state;

  always_comb begin
    next_state        = state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.ab_write      = 1'b0;
    bus.alu_out_write = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.alu_op        = ALU_NONE;
    bus.pc_source     = PCSRC_ALU;
    bus.exception     = 1'b0;

    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        bus.i_or_d = 1'b0;
        if (wait_done) next_state = S_FETCH_WB;
      end
      S_FETCH_WB: begin
        bus.ir_write  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALU_ADD;
        bus.pc_source = PCSRC_ALU;
        bus.pc_write  = 1'b1;
        next_state    = S_DECODE;
      end
      S_DECODE: begin
        bus.ab_write      = 1'b1;
        bus.alu_src_b     = SRCB_IMM_SH;
        bus.alu_op        = ALU_ADD;
        bus.alu_out_write = 1'b1;
        case (bus.opcode)
          OP_RTYPE:     next_state = S_EXEC_R;
          OP_ADDI:      next_state = S_EXEC_I;
          OP_LW, OP_SW: next_state = S_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_EXCEPT;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = SRCB_B;
        bus.alu_out_write = 1'b1;
        bus.alu_op        = r_op;
        // and cannot overflow, so only add/sub trap on the flag.
        if (r_op == ALU_NONE)                      next_state = S_EXCEPT;
        else if (bus.overflow && r_op != ALU_AND)  next_state = S_EXCEPT;
        else                                       next_state = S_WB_R;
      end
      S_WB_R: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        next_state    = S_FETCH;
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = SRCB_IMM;
        bus.alu_op        = ALU_ADD;
        bus.alu_out_write = 1'b1;
        if (bus.overflow)              next_state = S_EXCEPT;
        else if (state == S_EXEC_I)    next_state = S_WB_I;
        else if (bus.opcode == OP_LW)  next_state = S_MEM_RD;
        else if (bus.opcode == OP_SW)  next_state = S_MEM_WR;
        else                           next_state = S_EXCEPT;
      end
      S_WB_I: begin
        bus.reg_write = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEM_RD: begin
        bus.i_or_d = 1'b1;
        if (wait_done) next_state = S_WB_L;
      end
      S_WB_L: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        next_state     = S_FETCH;
      end
      S_MEM_WR: begin
        bus.i_or_d    = 1'b1;
        bus.mem_write = 1'b1;
        if (wait_done) next_state = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = SRCB_B;
        bus.alu_op        = ALU_SUB;
        bus.pc_source     = PCSRC_ALUOUT;
        bus.pc_write_cond = 1'b1;
        next_state        = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_source = PCSRC_JUMP;
        bus.pc_write  = 1'b1;
        next_state    = S_FETCH;
      end
      S_EXCEPT: begin
        bus.exception = 1'b1;
        next_state    = S_EXCEPT;
      end
      default: next_state = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (MEM_WAIT = 2 and 3) run directed and
// random instructions against a state-trace model built from instruction classes.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       exception;
  } outs_t;

  logic clk = 1'b0;
  logic rst2, rst3;

  mc_control_fsm_if bus2();
  mc_control_fsm_if bus3();

  mc_control_fsm #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(rst2), .bus(bus2));
  mc_control_fsm #(.MEM_WAIT(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- observation helpers ----------------
  outs_t o2, o3;
  assign o2 = {bus2.pc_write, bus2.pc_write_cond, bus2.i_or_d, bus2.mem_write,
               bus2.ir_write, bus2.ab_write, bus2.alu_out_write, bus2.reg_write,
               bus2.reg_dst, bus2.mem_to_reg, bus2.alu_src_a, bus2.alu_src_b,
               bus2.alu_op, bus2.pc_source, bus2.exception};
  assign o3 = {bus3.pc_write, bus3.pc_write_cond, bus3.i_or_d, bus3.mem_write,
               bus3.ir_write, bus3.ab_write, bus3.alu_out_write, bus3.reg_write,
               bus3.reg_dst, bus3.mem_to_reg, bus3.alu_src_a, bus3.alu_src_b,
               bus3.alu_op, bus3.pc_source, bus3.exception};

  function automatic outs_t dut_outs(input int w);
    return (w == 2) ? o2 : o3;
  endfunction

  function automatic logic [3:0] dut_state(input int w);
    return (w == 2) ? bus2.state_dbg : bus3.state_dbg;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected output word per state, straight from the state action list.
  function automatic outs_t exp_outs(input logic [3:0] s, input logic [5:0] fn);
    outs_t o;
    o = '0;
    case (s)
      4'd1:  o.i_or_d = 1'b1 & 1'b0;
      4'd2:  begin o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b001; o.pc_write = 1; end
      4'd3:  begin o.ab_write = 1; o.alu_src_b = 2'b11; o.alu_op = 3'b001; o.alu_out_write = 1; end
      4'd4:  begin
        o.alu_src_a = 1; o.alu_out_write = 1;
        o.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000;
      end
      4'd5:  begin o.reg_dst = 1; o.reg_write = 1; end
      4'd6, 4'd8: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b001; o.alu_out_write = 1; end
      4'd7:  o.reg_write = 1;
      4'd9:  o.i_or_d = 1;
      4'd10: begin o.mem_to_reg = 1; o.reg_write = 1; end
      4'd11: begin o.i_or_d = 1; o.mem_write = 1; end
      4'd12: begin o.alu_src_a = 1; o.alu_op = 3'b010; o.pc_source = 2'b01; o.pc_write_cond = 1; end
      4'd13: begin o.pc_source = 2'b10; o.pc_write = 1; end
      4'd14: o.exception = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Expected state_dbg trace of one instruction, from FETCH to its last state.
  task automatic build_trace(input int w, input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf);
    exp_q.delete();
    repeat (w) exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    case (op)
      6'h00: begin
        exp_q.push_back(4'd4);
        if (fn == 6'h24 || ((fn == 6'h20 || fn == 6'h22) && !ovf)) exp_q.push_back(4'd5);
        else exp_q.push_back(4'd14);
      end
      6'h08: begin
        exp_q.push_back(4'd6);
        exp_q.push_back(ovf ? 4'd14 : 4'd7);
      end
      6'h23: begin
        exp_q.push_back(4'd8);
        if (ovf) exp_q.push_back(4'd14);
        else begin
          repeat (w) exp_q.push_back(4'd9);
          exp_q.push_back(4'd10);
        end
      end
      6'h2B: begin
        exp_q.push_back(4'd8);
        if (ovf) exp_q.push_back(4'd14);
        else repeat (w) exp_q.push_back(4'd11);
      end
      6'h04:   exp_q.push_back(4'd12);
      6'h02:   exp_q.push_back(4'd13);
      default: exp_q.push_back(4'd14);
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_reset(input int w, input logic v);
    if (w == 2) rst2 = v;
    else        rst3 = v;
  endtask

  task automatic set_inputs(input int w, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic ovf);
    if (w == 2) begin
      bus2.opcode = op; bus2.funct = fn; bus2.zero = z; bus2.overflow = ovf;
    end else begin
      bus3.opcode = op; bus3.funct = fn; bus3.zero = z; bus3.overflow = ovf;
    end
  endtask

  // Called at a falling edge; leaves the instance in RESET, next state FETCH.
  task automatic do_reset(input int w);
    set_reset(w, 1'b1);
    @(negedge clk);
    check($sformatf("w%0d reset state", w), 32'(dut_state(w)), 32'd0);
    check($sformatf("w%0d reset outs", w), 32'(dut_outs(w)), 32'd0);
    set_reset(w, 1'b0);
  endtask

  // abort_idx >= 0 asserts reset at that trace position (after its check).
  task automatic run_instr(input int w, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ovf, input int abort_idx);
    logic [3:0] s, last;
    outs_t      o;
    int         idx, regw, memw, regw_exp, memw_exp;
    set_inputs(w, op, fn, z, ovf);
    build_trace(w, op, fn, ovf);
    regw_exp = 0;
    memw_exp = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i] == 4'd5 || exp_q[i] == 4'd7 || exp_q[i] == 4'd10) regw_exp++;
      if (exp_q[i] == 4'd11) memw_exp++;
    end
    last = exp_q[exp_q.size()-1];
    idx = 0; regw = 0; memw = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge clk);
      o = dut_outs(w);
      check($sformatf("w%0d op%02h fn%02h ovf%0d #%0d state", w, op, fn, ovf, idx),
            32'(dut_state(w)), 32'(s));
      check($sformatf("w%0d op%02h fn%02h ovf%0d #%0d outs", w, op, fn, ovf, idx),
            32'(o), 32'(exp_outs(s, fn)));
      regw += int'(o.reg_write);
      memw += int'(o.mem_write);
      if (idx == abort_idx) begin
        exp_q.delete();
        do_reset(w);
        return;
      end
      idx++;
    end
    check($sformatf("w%0d op%02h reg_write cycles", w, op), 32'(regw), 32'(regw_exp));
    check($sformatf("w%0d op%02h mem_write cycles", w, op), 32'(memw), 32'(memw_exp));
    if (last == 4'd14) begin
      repeat (3) begin
        @(negedge clk);
        o = dut_outs(w);
        check($sformatf("w%0d op%02h except hold state", w, op), 32'(dut_state(w)), 32'd14);
        check($sformatf("w%0d op%02h except hold outs", w, op), 32'(o), 32'(exp_outs(4'd14, fn)));
      end
      do_reset(w);
    end
  endtask

  // ---------------- stimulus ----------------
  localparam int NUM_RANDOM = 40;

  initial begin
    int         ws[2];
    logic [5:0] op, fn;
    logic [5:0] ops[7];
    logic [5:0] fns[3];
    ws  = '{2, 3};
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24};
    rst2 = 1'b1;
    rst3 = 1'b1;
    set_inputs(2, 6'h00, 6'h00, 1'b0, 1'b0);
    set_inputs(3, 6'h00, 6'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    foreach (ws[k]) begin
      do_reset(ws[k]);
      run_instr(ws[k], 6'h00, 6'h20, 1'b0, 1'b0, -1);   // add
      run_instr(ws[k], 6'h00, 6'h22, 1'b1, 1'b0, -1);   // sub
      run_instr(ws[k], 6'h00, 6'h24, 1'b0, 1'b1, -1);   // and ignores overflow
      run_instr(ws[k], 6'h00, 6'h22, 1'b0, 1'b1, -1);   // sub overflow traps
      run_instr(ws[k], 6'h00, 6'h27, 1'b0, 1'b0, -1);   // bad funct traps
      run_instr(ws[k], 6'h08, 6'h00, 1'b0, 1'b0, -1);   // addi
      run_instr(ws[k], 6'h08, 6'h00, 1'b0, 1'b1, -1);   // addi overflow traps
      run_instr(ws[k], 6'h23, 6'h00, 1'b0, 1'b0, -1);   // lw
      run_instr(ws[k], 6'h2B, 6'h00, 1'b0, 1'b0, -1);   // sw
      run_instr(ws[k], 6'h2B, 6'h00, 1'b0, 1'b1, -1);   // sw overflow traps
      run_instr(ws[k], 6'h04, 6'h00, 1'b1, 1'b0, -1);   // beq taken
      run_instr(ws[k], 6'h04, 6'h00, 1'b0, 1'b0, -1);   // beq not taken
      run_instr(ws[k], 6'h02, 6'h00, 1'b0, 1'b1, -1);   // j ignores overflow
      run_instr(ws[k], 6'h3F, 6'h00, 1'b0, 1'b0, -1);   // undefined opcode
      // lw with reset on the first MEM_RD cycle (trace index W+3)
      run_instr(ws[k], 6'h23, 6'h00, 1'b0, 1'b0, ws[k] + 3);
      run_instr(ws[k], 6'h00, 6'h24, 1'b0, 1'b0, -1);
      for (int i = 0; i < NUM_RANDOM; i++) begin
        op = ($urandom_range(0, 7) == 7) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
        fn = ($urandom_range(0, 5) == 5) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 2)];
        run_instr(ws[k], op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
      end
      set_reset(ws[k], 1'b1);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
